// File: rtl/control_unit_mc.sv
// control_unit_mc: registered, handshaked RV32I(+M) control decoder sitting
// between decode and execute. One control bundle per accepted instruction;
// a small FSM holds off issue while a multi-cycle MUL/DIV is in flight and
// while a FENCE drains.
//
// Ports
//   clock, reset          single clock, synchronous active-low reset
//   in_valid / in_ready   upstream handshake (in_ready is combinational on stall)
//   opcode/funct3/funct7  instruction fields
//   stall                 downstream cannot take the presented bundle
//   flush                 kill the presented bundle and any in-flight op
//   out_valid + bundle    registered control bundle
//   busy                  FSM is not in RUN
//   report                per-cycle trace print enable (simulation only)
module control_unit_mc #(
  parameter int unsigned CORE        = 0,
  parameter int unsigned M_EXT       = 1,
  parameter int unsigned MUL_CYCLES  = 2,
  parameter int unsigned DIV_CYCLES  = 32,
  parameter int unsigned FENCE_DRAIN = 4
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [6:0] opcode,
  input  logic [2:0] funct3,
  input  logic [6:0] funct7,
  input  logic       stall,
  input  logic       flush,
  output logic       out_valid,
  output logic       branch_op,
  output logic       memRead,
  output logic       memtoReg,
  output logic       memWrite,
  output logic       regWrite,
  output logic [2:0] ALUOp,
  output logic [2:0] muldiv_op,
  output logic [1:0] next_PC_sel,
  output logic [1:0] operand_A_sel,
  output logic       operand_B_sel,
  output logic [1:0] extend_sel,
  output logic       illegal,
  output logic       busy,
  input  logic       report
);

  // The same down-counter serves MUL/DIV latency and FENCE drain, so it is
  // sized for whichever is longer.
  localparam int unsigned CNT_MAX = (DIV_CYCLES > FENCE_DRAIN) ? DIV_CYCLES : FENCE_DRAIN;
  localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_FENCE  = 7'b0001111;
  localparam logic [6:0] F7_MULDIV = 7'b0000001;

  typedef enum logic [1:0] {
    S_RUN     = 2'd0,
    S_MD_WAIT = 2'd1,
    S_DRAIN   = 2'd2
  } state_t;

  typedef struct packed {
    logic       branch_op;
    logic       mem_read;
    logic       mem_to_reg;
    logic       mem_write;
    logic       reg_write;
    logic [2:0] alu_op;
    logic [2:0] muldiv_op;
    logic [1:0] next_pc_sel;
    logic [1:0] operand_a_sel;
    logic       operand_b_sel;
    logic [1:0] extend_sel;
    logic       illegal;
  } bundle_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             out_valid_q, out_valid_d;
  logic             busy_q, busy_d;
  bundle_t          bundle_q, bundle_d;
  logic [31:0]      cyc_q;

  bundle_t          dec_c;
  logic             is_md_c;
  logic             is_fence_c;
  int unsigned      md_lat_c;
  logic             accept_c;
  logic             hold_c;

  // Instruction decode into a control bundle
  always_comb begin
    dec_c      = '0;
    is_md_c    = 1'b0;
    is_fence_c = 1'b0;
    case (opcode)
      OP_R: begin
        if (funct7 == F7_MULDIV) begin
          if (M_EXT != 0) begin
            is_md_c           = 1'b1;
            dec_c.reg_write   = 1'b1;
            dec_c.alu_op      = 3'b111;
            dec_c.muldiv_op   = funct3;
          end else begin
            dec_c.illegal     = 1'b1;
          end
        end else begin
          dec_c.reg_write     = 1'b1;
          dec_c.alu_op        = 3'b000;
        end
      end
      OP_I: begin
        dec_c.reg_write     = 1'b1;
        dec_c.alu_op        = 3'b001;
        dec_c.operand_b_sel = 1'b1;
        dec_c.extend_sel    = 2'b00;
      end
      OP_STORE: begin
        dec_c.mem_write     = 1'b1;
        dec_c.alu_op        = 3'b101;
        dec_c.operand_b_sel = 1'b1;
        dec_c.extend_sel    = 2'b01;
      end
      OP_LOAD: begin
        dec_c.mem_read      = 1'b1;
        dec_c.mem_to_reg    = 1'b1;
        dec_c.reg_write     = 1'b1;
        dec_c.alu_op        = 3'b100;
        dec_c.operand_b_sel = 1'b1;
        dec_c.extend_sel    = 2'b00;
      end
      OP_BRANCH: begin
        dec_c.branch_op     = 1'b1;
        dec_c.alu_op        = 3'b010;
        dec_c.next_pc_sel   = 2'b01;
      end
      OP_JAL: begin
        dec_c.reg_write     = 1'b1;
        dec_c.alu_op        = 3'b011;
        dec_c.next_pc_sel   = 2'b10;
        dec_c.operand_a_sel = 2'b10;
      end
      OP_JALR: begin
        dec_c.reg_write     = 1'b1;
        dec_c.alu_op        = 3'b011;
        dec_c.next_pc_sel   = 2'b11;
        dec_c.operand_a_sel = 2'b10;
      end
      OP_AUIPC: begin
        dec_c.reg_write     = 1'b1;
        dec_c.alu_op        = 3'b110;
        dec_c.operand_a_sel = 2'b01;
        dec_c.operand_b_sel = 1'b1;
        dec_c.extend_sel    = 2'b10;
      end
      OP_LUI: begin
        dec_c.reg_write     = 1'b1;
        dec_c.alu_op        = 3'b110;
        dec_c.operand_a_sel = 2'b11;
        dec_c.operand_b_sel = 1'b1;
        dec_c.extend_sel    = 2'b10;
      end
      OP_FENCE: begin
        // Bubble: everything stays 0.
        is_fence_c = 1'b1;
      end
      default: begin
        // SYSCALL and unknown opcodes.
        dec_c.illegal = 1'b1;
      end
    endcase
  end

  assign md_lat_c = funct3[2] ? DIV_CYCLES : MUL_CYCLES;
  assign hold_c   = out_valid_q && stall;
  assign in_ready = (state_q == S_RUN) && !hold_c;
  assign accept_c = in_valid && in_ready;

  // Next-state: reset > flush > stall hold > counter expiry > new accept
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    out_valid_d = out_valid_q;
    bundle_d    = bundle_q;
    busy_d      = busy_q;
    if (flush) begin
      out_valid_d      = 1'b0;
      bundle_d.illegal = 1'b0;
      state_d          = S_RUN;
      cnt_d            = '0;
    end else if (!hold_c) begin
      case (state_q)
        S_RUN: begin
          out_valid_d = 1'b0;
          if (accept_c) begin
            bundle_d = dec_c;
            if (is_md_c && (md_lat_c > 1)) begin
              // Result appears when the counter runs out.
              state_d = S_MD_WAIT;
              cnt_d   = CNT_W'(md_lat_c - 1);
            end else begin
              out_valid_d = 1'b1;
              if (is_fence_c) begin
                state_d = S_DRAIN;
                cnt_d   = CNT_W'(FENCE_DRAIN - 1);
              end
            end
          end
        end
        S_MD_WAIT: begin
          if (cnt_q <= CNT_W'(1)) begin
            out_valid_d = 1'b1;
            state_d     = S_RUN;
            cnt_d       = '0;
          end else begin
            cnt_d = CNT_W'(cnt_q - 1'b1);
          end
        end
        S_DRAIN: begin
          out_valid_d = 1'b0;
          if (cnt_q == '0) begin
            state_d = S_RUN;
          end else begin
            cnt_d = CNT_W'(cnt_q - 1'b1);
          end
        end
        default: begin
          state_d = S_RUN;
          cnt_d   = '0;
        end
      endcase
    end
    busy_d = (state_d != S_RUN);
  end

  // State and output registers
  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q     <= S_RUN;
      cnt_q       <= '0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      bundle_q    <= '0;
      cyc_q       <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
      bundle_q    <= bundle_d;
      cyc_q       <= cyc_q + 32'd1;
    end
  end

  assign out_valid     = out_valid_q;
  assign busy          = busy_q;
  assign branch_op     = bundle_q.branch_op;
  assign memRead       = bundle_q.mem_read;
  assign memtoReg      = bundle_q.mem_to_reg;
  assign memWrite      = bundle_q.mem_write;
  assign regWrite      = bundle_q.reg_write;
  assign ALUOp         = bundle_q.alu_op;
  assign muldiv_op     = bundle_q.muldiv_op;
  assign next_PC_sel   = bundle_q.next_pc_sel;
  assign operand_A_sel = bundle_q.operand_a_sel;
  assign operand_B_sel = bundle_q.operand_b_sel;
  assign extend_sel    = bundle_q.extend_sel;
  assign illegal       = bundle_q.illegal;

`ifndef SYNTHESIS
  // Per-cycle trace of the presented bundle
  always_ff @(posedge clock) begin
    if (reset && report) begin
      $display("core=%0d cycle=%0d opcode=%b in_ready=%b out_valid=%b busy=%b br=%b mr=%b m2r=%b mw=%b rw=%b alu=%b md=%b npc=%b asel=%b bsel=%b ext=%b ill=%b",
               CORE, cyc_q, opcode, in_ready, out_valid, busy, branch_op, memRead,
               memtoReg, memWrite, regWrite, ALUOp, muldiv_op, next_PC_sel,
               operand_A_sel, operand_B_sel, extend_sel, illegal);
    end
  end
`endif

endmodule

// File: tb/tb_control_unit_mc.sv
module tb_control_unit_mc;

  localparam int MUL_LAT = 2;
  localparam int DIV_LAT = 32;
  localparam int DRAIN   = 4;

  logic       clock = 1'b0;
  logic       reset;
  logic       in_valid;
  logic       in_ready;
  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;
  logic       stall;
  logic       flush;
  logic       out_valid;
  logic       branch_op, memRead, memtoReg, memWrite, regWrite;
  logic [2:0] ALUOp, muldiv_op;
  logic [1:0] next_PC_sel, operand_A_sel, extend_sel;
  logic       operand_B_sel, illegal, busy;
  logic       report;

  control_unit_mc #(
    .CORE(0), .M_EXT(1), .MUL_CYCLES(MUL_LAT), .DIV_CYCLES(DIV_LAT), .FENCE_DRAIN(DRAIN)
  ) dut (
    .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .opcode(opcode), .funct3(funct3), .funct7(funct7), .stall(stall), .flush(flush),
    .out_valid(out_valid), .branch_op(branch_op), .memRead(memRead), .memtoReg(memtoReg),
    .memWrite(memWrite), .regWrite(regWrite), .ALUOp(ALUOp), .muldiv_op(muldiv_op),
    .next_PC_sel(next_PC_sel), .operand_A_sel(operand_A_sel), .operand_B_sel(operand_B_sel),
    .extend_sel(extend_sel), .illegal(illegal), .busy(busy), .report(report)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic       br, mr, mtr, mw, rw;
    logic [2:0] alu, md;
    logic [1:0] npc, asel;
    logic       bsel;
    logic [1:0] ext;
    logic       ill;
  } bundle_t;

  typedef struct {
    bundle_t b;
    int      due;
  } exp_t;

  exp_t    q[$];
  int      cyc = 0;
  int      total = 0;
  int      bad = 0;
  int      busy_until = -1;
  int      no_stall_cyc = -1;
  logic    exp_ready = 1'b0;
  logic    m_exp_ov, m_exp_busy;
  bundle_t act_b;

  assign act_b = {branch_op, memRead, memtoReg, memWrite, regWrite, ALUOp, muldiv_op,
                  next_PC_sel, operand_A_sel, operand_B_sel, extend_sel, illegal};

  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] a, input logic [31:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s cycle=%0d got=%h want=%h", nm, cyc, a, e);
    end
  endtask

  // Reference decode written straight from the opcode table.
  function automatic bundle_t ref_bundle(input logic [6:0] op, input logic [2:0] f3,
                                         input logic [6:0] f7);
    bundle_t b = '0;
    case (op)
      7'b0110011: begin b.rw = 1; if (f7 == 7'b0000001) begin b.alu = 3'b111; b.md = f3; end end
      7'b0010011: begin b.rw = 1; b.alu = 3'b001; b.bsel = 1; end
      7'b0100011: begin b.mw = 1; b.alu = 3'b101; b.bsel = 1; b.ext = 2'b01; end
      7'b0000011: begin b.mr = 1; b.mtr = 1; b.rw = 1; b.alu = 3'b100; b.bsel = 1; end
      7'b1100011: begin b.br = 1; b.alu = 3'b010; b.npc = 2'b01; end
      7'b1101111: begin b.rw = 1; b.alu = 3'b011; b.npc = 2'b10; b.asel = 2'b10; end
      7'b1100111: begin b.rw = 1; b.alu = 3'b011; b.npc = 2'b11; b.asel = 2'b10; end
      7'b0010111: begin b.rw = 1; b.alu = 3'b110; b.asel = 2'b01; b.bsel = 1; b.ext = 2'b10; end
      7'b0110111: begin b.rw = 1; b.alu = 3'b110; b.asel = 2'b11; b.bsel = 1; b.ext = 2'b10; end
      7'b0001111: ;
      default:    b.ill = 1;
    endcase
    return b;
  endfunction

  function automatic int ref_lat(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7);
    if (op == 7'b0110011 && f7 == 7'b0000001) return f3[2] ? DIV_LAT : MUL_LAT;
    return 1;
  endfunction

  // Monitor: compare handshake and the presented bundle against the scoreboard
  always @(negedge clock) begin
    if (!reset) begin
      exp_ready = 1'b0;
    end else begin
      m_exp_ov   = (q.size() > 0) && (q[0].due <= cyc);
      m_exp_busy = (cyc <= busy_until);
      exp_ready  = !m_exp_busy && !(m_exp_ov && stall);
      chk("out_valid", 32'(out_valid), 32'(m_exp_ov));
      chk("busy", 32'(busy), 32'(m_exp_busy));
      chk("in_ready", 32'(in_ready), 32'(exp_ready));
      if (m_exp_ov) begin
        if (out_valid) chk("bundle", 32'(act_b), 32'(q[0].b));
        if (!stall || flush) void'(q.pop_front());
      end
    end
  end

  // One clock of stimulus; model bookkeeping runs after the monitor.
  task automatic step(input logic iv, input logic [6:0] op, input logic [2:0] f3,
                      input logic [6:0] f7, input logic st, input logic fl,
                      input logic rst_n, output bit acc);
    exp_t e;
    int   lat;
    @(posedge clock); #1;
    in_valid = iv; opcode = op; funct3 = f3; funct7 = f7;
    stall = (cyc == no_stall_cyc) ? 1'b0 : st;
    flush = fl; reset = rst_n;
    @(negedge clock); #1;
    acc = 0;
    if (!reset) begin
      q.delete();
      busy_until = -1;
    end else if (flush) begin
      q.delete();
      if (busy_until > cyc) busy_until = cyc;
    end else if (in_valid && exp_ready) begin
      acc   = 1;
      lat   = ref_lat(op, f3, f7);
      e.b   = ref_bundle(op, f3, f7);
      e.due = cyc + lat;
      q.push_back(e);
      if (lat > 1) busy_until = cyc + lat - 1;
      if (op == 7'b0001111) begin
        busy_until   = cyc + DRAIN;
        no_stall_cyc = cyc + 1;
      end
    end
  endtask

  task automatic idle(input int n);
    bit a;
    repeat (n) step(0, 7'h0, 3'h0, 7'h0, 0, 0, 1, a);
  endtask

  task automatic issue(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7);
    bit done = 0;
    for (int i = 0; i < 100 && !done; i++) step(1, op, f3, f7, 0, 0, 1, done);
    if (!done) begin
      total++; bad++;
      $display("FAIL issue_timeout cycle=%0d got=not_accepted want=accepted", cyc);
    end
  endtask

  localparam int NOPS = 13;
  logic [6:0] op_tab [NOPS] = '{7'b0110011, 7'b0010011, 7'b0100011, 7'b0000011, 7'b1100011,
                                7'b1101111, 7'b1100111, 7'b0010111, 7'b0110111, 7'b0001111,
                                7'b1110011, 7'b1111111, 7'b0101010};

  initial begin
    bit a;
    logic [6:0] rop, rf7;
    reset = 0; in_valid = 0; opcode = 0; funct3 = 0; funct7 = 0;
    stall = 0; flush = 0; report = 0;

    repeat (3) step(0, 7'h0, 3'h0, 7'h0, 0, 0, 0, a);
    step(0, 7'h0, 3'h0, 7'h0, 0, 0, 1, a);
    chk("reset_bundle", 32'(act_b), 32'h0);

    // ADDI
    issue(7'b0010011, 3'b000, 7'h0);
    idle(3);
    // DIV: long MD_WAIT
    issue(7'b0110011, 3'b100, 7'b0000001);
    idle(DIV_LAT + 3);
    // LW held by stall, then next instruction taken the cycle stall falls
    issue(7'b0000011, 3'b010, 7'h0);
    repeat (3) step(1, 7'b0110011, 3'b000, 7'h0, 1, 0, 1, a);
    step(1, 7'b0110011, 3'b000, 7'h0, 0, 0, 1, a);
    idle(2);
    // FENCE drain followed immediately by an ADDI
    issue(7'b0001111, 3'b000, 7'h0);
    issue(7'b0010011, 3'b000, 7'h0);
    idle(2);
    // MUL killed by flush in its first wait cycle
    issue(7'b0110011, 3'b000, 7'b0000001);
    step(0, 7'h0, 3'h0, 7'h0, 0, 1, 1, a);
    idle(4);
    // Reset during DIV wait, then an unknown opcode
    issue(7'b0110011, 3'b101, 7'b0000001);
    idle(5);
    step(0, 7'h0, 3'h0, 7'h0, 0, 0, 0, a);
    step(0, 7'h0, 3'h0, 7'h0, 0, 0, 1, a);
    chk("reset_mid_div_bundle", 32'(act_b), 32'h0);
    issue(7'b1111111, 3'b000, 7'h0);
    idle(3);

    // Randomized traffic
    report = 0;
    for (int i = 0; i < 800; i++) begin
      rop = op_tab[$urandom_range(NOPS - 1)];
      rf7 = 7'h0;
      if (rop == 7'b0110011) begin
        case ($urandom_range(3))
          0: rf7 = 7'b0000001;
          1: rf7 = 7'b0100000;
          default: rf7 = 7'h0;
        endcase
      end
      step(($urandom_range(9) < 7), rop, 3'($urandom_range(7)), rf7,
           ($urandom_range(3) == 0), ($urandom_range(39) == 0),
           ($urandom_range(199) != 0), a);
    end

    for (int i = 0; i < 100 && q.size() > 0; i++) idle(1);
    chk("queue_empty", 32'(q.size()), 32'h0);
    idle(2);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
